// File: rtl/forward_ctrl_pkg.sv
// Shared constants for the forwarding controller and the EX-stage datapath.
// The bypass mux in bypass_path and the select logic in forward_ctrl both
// read the SEL_* encodings from here so the two can never drift apart.
package forward_ctrl_pkg;

    // EX operand-select encodings
    localparam logic [1:0] SEL_REG = 2'd0;  // register-file read data
    localparam logic [1:0] SEL_MEM = 2'd1;  // result currently in MEM
    localparam logic [1:0] SEL_WB  = 2'd2;  // result currently in WB

    // ALU function codes driven from decode into EX
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8,
        ALU_LUI = 4'd9
    } alu_fn_e;

    // Priority pick for one operand: the younger producer (in EX now, in MEM
    // next cycle) wins over the older one (in MEM now, in WB next cycle).
    function automatic logic [1:0] pick_sel(input logic hit_ex, input logic hit_mem);
        logic [1:0] sel;
        sel = SEL_REG;
        if (hit_ex) begin
            sel = SEL_MEM;
        end else if (hit_mem) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/forward_ctrl_stage_reg.sv
// One pipeline tracking entry: valid / rd / we / is_load of the instruction
// occupying a stage. A bubble clears the entry so it can never be a
// forwarding source.
module fwd_stage_reg #(
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bubble,
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_we,
    input  logic              i_is_load,
    output logic              o_valid,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_we,
    output logic              o_is_load
);

    logic              r_valid;
    logic [REG_AW-1:0] r_rd;
    logic              r_we;
    logic              r_is_load;

    // Capture the upstream entry, or a cleared entry when a bubble is inserted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_rd      <= '0;
            r_we      <= 1'b0;
            r_is_load <= 1'b0;
        end else if (i_bubble) begin
            r_valid   <= 1'b0;
            r_rd      <= '0;
            r_we      <= 1'b0;
            r_is_load <= 1'b0;
        end else begin
            r_valid   <= i_valid;
            r_rd      <= i_rd;
            r_we      <= i_we;
            r_is_load <= i_is_load;
        end
    end

    assign o_valid   = r_valid;
    assign o_rd      = r_rd;
    assign o_we      = r_we;
    assign o_is_load = r_is_load;

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding / load-use hazard controller for a 5-stage pipeline.
// Tracks the destination of the instructions in EX, MEM and WB, raises a
// one-cycle STALL on a load-use hazard and registers the EX operand bypass
// selects one cycle ahead. WB-to-ID hazards are handled by the write-first
// register file, so the WB entry is tracked but never used as a source.
module forward_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ID_VALID,
    input  logic [REG_AW-1:0] ID_RS,
    input  logic [REG_AW-1:0] ID_RT,
    input  logic              ID_USES_RS,
    input  logic              ID_USES_RT,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_REG_WE,
    input  logic              ID_IS_LOAD,
    input  logic              FLUSH,
    output logic              STALL,
    output logic [1:0]        BYPASS_SEL_A,
    output logic [1:0]        BYPASS_SEL_B,
    output logic [CNT_W-1:0]  STALL_CNT
);

    import forward_ctrl_pkg::*;

    logic              w_ex_valid;
    logic [REG_AW-1:0] w_ex_rd;
    logic              w_ex_we;
    logic              w_ex_is_load;
    logic              w_mem_valid;
    logic [REG_AW-1:0] w_mem_rd;
    logic              w_mem_we;
    logic              w_mem_is_load;
    logic              w_wb_valid;
    logic [REG_AW-1:0] w_wb_rd;
    logic              w_wb_we;
    logic              w_wb_is_load;

    logic              w_ex_qual;
    logic              w_mem_qual;
    logic              w_rs_hit_ex;
    logic              w_rt_hit_ex;
    logic              w_rs_hit_mem;
    logic              w_rt_hit_mem;
    logic              w_stall;
    logic              w_load_ex;
    logic [1:0]        w_sel_a_nxt;
    logic [1:0]        w_sel_b_nxt;
    logic              w_unused;

    logic [1:0]        r_sel_a;
    logic [1:0]        r_sel_b;
    logic [CNT_W-1:0]  r_stall_cnt;

    // EX entry: loads the decode instruction or takes a bubble
    fwd_stage_reg #(.REG_AW(REG_AW)) u_stage_ex (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_bubble  (~w_load_ex),
        .i_valid   (ID_VALID),
        .i_rd      (ID_RD),
        .i_we      (ID_REG_WE),
        .i_is_load (ID_IS_LOAD),
        .o_valid   (w_ex_valid),
        .o_rd      (w_ex_rd),
        .o_we      (w_ex_we),
        .o_is_load (w_ex_is_load)
    );

    // MEM entry: unconditionally follows EX
    fwd_stage_reg #(.REG_AW(REG_AW)) u_stage_mem (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_bubble  (1'b0),
        .i_valid   (w_ex_valid),
        .i_rd      (w_ex_rd),
        .i_we      (w_ex_we),
        .i_is_load (w_ex_is_load),
        .o_valid   (w_mem_valid),
        .o_rd      (w_mem_rd),
        .o_we      (w_mem_we),
        .o_is_load (w_mem_is_load)
    );

    // WB entry: unconditionally follows MEM
    fwd_stage_reg #(.REG_AW(REG_AW)) u_stage_wb (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_bubble  (1'b0),
        .i_valid   (w_mem_valid),
        .i_rd      (w_mem_rd),
        .i_we      (w_mem_we),
        .i_is_load (w_mem_is_load),
        .o_valid   (w_wb_valid),
        .o_rd      (w_wb_rd),
        .o_we      (w_wb_we),
        .o_is_load (w_wb_is_load)
    );

    // An entry can feed a bypass only if it really writes a non-zero register
    assign w_ex_qual  = w_ex_valid  & w_ex_we  & (w_ex_rd  != '0);
    assign w_mem_qual = w_mem_valid & w_mem_we & (w_mem_rd != '0);

    assign w_rs_hit_ex  = ID_USES_RS & w_ex_qual  & (w_ex_rd  == ID_RS);
    assign w_rt_hit_ex  = ID_USES_RT & w_ex_qual  & (w_ex_rd  == ID_RT);
    assign w_rs_hit_mem = ID_USES_RS & w_mem_qual & (w_mem_rd == ID_RS);
    assign w_rt_hit_mem = ID_USES_RT & w_mem_qual & (w_mem_rd == ID_RT);

    // Load data is not available until the load reaches WB, so a consumer
    // directly behind a load waits one cycle. A flush kills the consumer, so
    // there is nothing to stall.
    assign w_stall   = ID_VALID & ~FLUSH & w_ex_is_load & (w_rs_hit_ex | w_rt_hit_ex);
    assign w_load_ex = ID_VALID & ~w_stall & ~FLUSH;

    // A bubble entering EX must not inherit a select from the killed/held
    // instruction; a load hit in EX never reaches here because it stalls.
    assign w_sel_a_nxt = w_load_ex ? pick_sel(w_rs_hit_ex, w_rs_hit_mem) : SEL_REG;
    assign w_sel_b_nxt = w_load_ex ? pick_sel(w_rt_hit_ex, w_rt_hit_mem) : SEL_REG;

    // Register the operand selects so they line up with the instruction in EX
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sel_a <= SEL_REG;
            r_sel_b <= SEL_REG;
        end else begin
            r_sel_a <= w_sel_a_nxt;
            r_sel_b <= w_sel_b_nxt;
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // WB entry and the MEM load flag are tracked for completeness only
    assign w_unused = ^{w_mem_is_load, w_wb_valid, w_wb_rd, w_wb_we, w_wb_is_load};

    assign STALL        = w_stall;
    assign BYPASS_SEL_A = r_sel_a;
    assign BYPASS_SEL_B = r_sel_b;
    assign STALL_CNT    = r_stall_cnt;

endmodule

// File: tb/tb_forward_ctrl.sv
// Self-checking bench for forward_ctrl: directed pipeline scenarios plus
// randomized instruction streams against a history-based reference model.
module tb_forward_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        ID_VALID;
    logic [4:0]  ID_RS;
    logic [4:0]  ID_RT;
    logic        ID_USES_RS;
    logic        ID_USES_RT;
    logic [4:0]  ID_RD;
    logic        ID_REG_WE;
    logic        ID_IS_LOAD;
    logic        FLUSH;
    logic        STALL;
    logic [1:0]  BYPASS_SEL_A;
    logic [1:0]  BYPASS_SEL_B;
    logic [15:0] STALL_CNT;
    logic        STALL2;
    logic [1:0]  SEL_A2;
    logic [1:0]  SEL_B2;
    logic [1:0]  CNT2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       flush;
    } instr_t;

    // Reference state: what entered EX on recent edges (index 0 = now in EX)
    instr_t hist[$];
    int     mcnt;
    logic   obs_stall;
    logic   obs_stall2;

    forward_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_USES_RS(ID_USES_RS), .ID_USES_RT(ID_USES_RT), .ID_RD(ID_RD),
        .ID_REG_WE(ID_REG_WE), .ID_IS_LOAD(ID_IS_LOAD), .FLUSH(FLUSH),
        .STALL(STALL), .BYPASS_SEL_A(BYPASS_SEL_A), .BYPASS_SEL_B(BYPASS_SEL_B),
        .STALL_CNT(STALL_CNT)
    );

    forward_ctrl #(.REG_AW(5), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .ID_RS(ID_RS), .ID_RT(ID_RT),
        .ID_USES_RS(ID_USES_RS), .ID_USES_RT(ID_USES_RT), .ID_RD(ID_RD),
        .ID_REG_WE(ID_REG_WE), .ID_IS_LOAD(ID_IS_LOAD), .FLUSH(FLUSH),
        .STALL(STALL2), .BYPASS_SEL_A(SEL_A2), .BYPASS_SEL_B(SEL_B2),
        .STALL_CNT(CNT2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic instr_t mk(logic v, logic [4:0] rd, logic we, logic ld,
                                  logic [4:0] rs, logic urs, logic [4:0] rt,
                                  logic urt, logic fl);
        instr_t t;
        t.valid = v; t.rd = rd; t.we = we; t.ld = ld;
        t.rs = rs; t.urs = urs; t.rt = rt; t.urt = urt; t.flush = fl;
        return t;
    endfunction

    function automatic instr_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic writes(instr_t e, logic [4:0] r);
        return e.valid && e.we && (e.rd != 0) && (e.rd == r);
    endfunction

    function automatic logic model_stall(instr_t i);
        if (!i.valid || i.flush || hist.size() == 0) return 1'b0;
        return hist[0].ld && ((i.urs && writes(hist[0], i.rs)) ||
                              (i.urt && writes(hist[0], i.rt)));
    endfunction

    function automatic logic [1:0] model_sel(logic use_r, logic [4:0] r);
        if (!use_r) return 2'd0;
        if (hist.size() > 0 && writes(hist[0], r)) return 2'd1;
        if (hist.size() > 1 && writes(hist[1], r)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int sat3(int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic drive(instr_t i);
        ID_VALID = i.valid; ID_RD = i.rd; ID_REG_WE = i.we; ID_IS_LOAD = i.ld;
        ID_RS = i.rs; ID_USES_RS = i.urs; ID_RT = i.rt; ID_USES_RT = i.urt;
        FLUSH = i.flush;
    endtask

    // Present one decode instruction for one cycle; returns model expectations
    // and leaves the bench 1 time unit after the edge.
    task automatic cycle(input instr_t ins, output logic e_stall,
                         output logic [1:0] e_a, output logic [1:0] e_b);
        logic issue;
        drive(ins);
        e_stall = model_stall(ins);
        issue   = ins.valid && !e_stall && !ins.flush;
        e_a     = issue ? model_sel(ins.urs, ins.rs) : 2'd0;
        e_b     = issue ? model_sel(ins.urt, ins.rt) : 2'd0;
        @(negedge CLK);
        obs_stall  = STALL;
        obs_stall2 = STALL2;
        @(posedge CLK);
        #1;
        if (e_stall) mcnt++;
        hist.push_front(issue ? ins : bubble());
        if (hist.size() > 2) void'(hist.pop_back());
    endtask

    task automatic test_reset();
        drive(bubble());
        RST_N = 1'b0;
        hist.delete();
        mcnt = 0;
        #2;
        n_checks++;
        if (STALL !== 1'b0 || BYPASS_SEL_A !== 2'd0 || BYPASS_SEL_B !== 2'd0 || STALL_CNT !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%b a=%0d b=%0d cnt=%0d required 0/0/0/0",
                     STALL, BYPASS_SEL_A, BYPASS_SEL_B, STALL_CNT);
        end
        #10 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        hist.push_front(bubble());
    endtask

    task automatic test_directed();
        logic es;
        logic [1:0] ea, eb;
        // ADD r3 ; SUB r4,r3,r5
        cycle(mk(1, 3, 1, 0, 1, 1, 2, 1, 0), es, ea, eb);
        cycle(mk(1, 4, 1, 0, 3, 1, 5, 1, 0), es, ea, eb);
        n_checks++;
        if (BYPASS_SEL_A !== 2'd1 || BYPASS_SEL_B !== 2'd0) begin
            n_fail++;
            $display("FAIL ex_fwd: a=%0d b=%0d required 1/0", BYPASS_SEL_A, BYPASS_SEL_B);
        end
        // ADD r3 ; NOP ; OR r6,r1,r3
        cycle(mk(1, 3, 1, 0, 1, 1, 2, 1, 0), es, ea, eb);
        cycle(bubble(), es, ea, eb);
        cycle(mk(1, 6, 1, 0, 1, 1, 3, 1, 0), es, ea, eb);
        n_checks++;
        if (BYPASS_SEL_A !== 2'd0 || BYPASS_SEL_B !== 2'd2) begin
            n_fail++;
            $display("FAIL mem_fwd: a=%0d b=%0d required 0/2", BYPASS_SEL_A, BYPASS_SEL_B);
        end
        // LW r7 ; ADD r8,r7,r7 (stalls once, then retried)
        cycle(mk(1, 7, 1, 1, 1, 1, 0, 0, 0), es, ea, eb);
        cycle(mk(1, 8, 1, 0, 7, 1, 7, 1, 0), es, ea, eb);
        n_checks++;
        if (obs_stall !== 1'b1 || STALL_CNT !== 16'd1 || BYPASS_SEL_A !== 2'd0 || BYPASS_SEL_B !== 2'd0) begin
            n_fail++;
            $display("FAIL load_use_stall: stall=%b cnt=%0d a=%0d b=%0d required 1/1/0/0",
                     obs_stall, STALL_CNT, BYPASS_SEL_A, BYPASS_SEL_B);
        end
        cycle(mk(1, 8, 1, 0, 7, 1, 7, 1, 0), es, ea, eb);
        n_checks++;
        if (obs_stall !== 1'b0 || STALL_CNT !== 16'd1 || BYPASS_SEL_A !== 2'd2 || BYPASS_SEL_B !== 2'd2) begin
            n_fail++;
            $display("FAIL load_use_retry: stall=%b cnt=%0d a=%0d b=%0d required 0/1/2/2",
                     obs_stall, STALL_CNT, BYPASS_SEL_A, BYPASS_SEL_B);
        end
        // ADD r0 ; reader of r0
        cycle(mk(1, 0, 1, 0, 1, 1, 2, 1, 0), es, ea, eb);
        cycle(mk(1, 9, 1, 0, 0, 1, 0, 1, 0), es, ea, eb);
        n_checks++;
        if (obs_stall !== 1'b0 || BYPASS_SEL_A !== 2'd0 || BYPASS_SEL_B !== 2'd0) begin
            n_fail++;
            $display("FAIL r0_no_fwd: stall=%b a=%0d b=%0d required 0/0/0", obs_stall, BYPASS_SEL_A, BYPASS_SEL_B);
        end
        // LW r7 ; r7 reader killed by FLUSH
        cycle(mk(1, 7, 1, 1, 1, 1, 0, 0, 0), es, ea, eb);
        cycle(mk(1, 9, 1, 0, 7, 1, 7, 1, 1), es, ea, eb);
        n_checks++;
        if (obs_stall !== 1'b0 || STALL_CNT !== 16'd1 || BYPASS_SEL_A !== 2'd0 || BYPASS_SEL_B !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_over_stall: stall=%b cnt=%0d a=%0d b=%0d required 0/1/0/0",
                     obs_stall, STALL_CNT, BYPASS_SEL_A, BYPASS_SEL_B);
        end
        // ADD r2 ; SUB r2 ; reader of r2 (younger wins)
        cycle(mk(1, 2, 1, 0, 1, 1, 1, 1, 0), es, ea, eb);
        cycle(mk(1, 2, 1, 0, 1, 1, 1, 1, 0), es, ea, eb);
        cycle(mk(1, 10, 1, 0, 2, 1, 2, 1, 0), es, ea, eb);
        n_checks++;
        if (BYPASS_SEL_A !== 2'd1 || BYPASS_SEL_B !== 2'd1) begin
            n_fail++;
            $display("FAIL younger_wins: a=%0d b=%0d required 1/1", BYPASS_SEL_A, BYPASS_SEL_B);
        end
    endtask

    task automatic test_saturation();
        logic es;
        logic [1:0] ea, eb;
        for (int k = 0; k < 5; k++) begin
            cycle(mk(1, 7, 1, 1, 1, 1, 0, 0, 0), es, ea, eb);
            cycle(mk(1, 8, 1, 0, 7, 1, 0, 0, 0), es, ea, eb);
            cycle(mk(1, 8, 1, 0, 7, 1, 0, 0, 0), es, ea, eb);
            n_checks++;
            if (STALL_CNT !== 16'(mcnt) || CNT2 !== 2'(sat3(mcnt))) begin
                n_fail++;
                $display("FAIL stall_cnt_sat[%0d]: cnt=%0d cnt2=%0d required %0d/%0d",
                         k, STALL_CNT, CNT2, mcnt, sat3(mcnt));
            end
        end
        n_checks++;
        if (CNT2 !== 2'd3) begin
            n_fail++;
            $display("FAIL cnt_w2_saturated: cnt2=%0d required 3", CNT2);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic es;
        logic [1:0] ea, eb;
        cycle(mk(1, 9, 1, 1, 1, 1, 0, 0, 0), es, ea, eb);
        drive(mk(1, 11, 1, 0, 9, 1, 9, 1, 0));
        @(negedge CLK);
        n_checks++;
        if (STALL !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_stall_setup: stall=%b required 1", STALL);
        end
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (STALL !== 1'b0 || BYPASS_SEL_A !== 2'd0 || BYPASS_SEL_B !== 2'd0 || STALL_CNT !== 16'd0 || CNT2 !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: stall=%b a=%0d b=%0d cnt=%0d cnt2=%0d required all 0",
                     STALL, BYPASS_SEL_A, BYPASS_SEL_B, STALL_CNT, CNT2);
        end
        drive(bubble());
        #1 RST_N = 1'b1;
        hist.delete();
        mcnt = 0;
        @(posedge CLK);
        #1;
        hist.push_front(bubble());
        cycle(mk(1, 12, 1, 0, 9, 1, 9, 1, 0), es, ea, eb);
        n_checks++;
        if (obs_stall !== 1'b0 || BYPASS_SEL_A !== 2'd0 || BYPASS_SEL_B !== 2'd0) begin
            n_fail++;
            $display("FAIL no_stale_after_reset: stall=%b a=%0d b=%0d required 0/0/0",
                     obs_stall, BYPASS_SEL_A, BYPASS_SEL_B);
        end
    endtask

    task automatic test_random();
        logic es;
        logic [1:0] ea, eb;
        instr_t t;
        for (int n = 0; n < 400; n++) begin
            t = mk($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                   $urandom_range(0, 9) < 3, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            cycle(t, es, ea, eb);
            n_checks++;
            if (obs_stall !== es || obs_stall2 !== es || BYPASS_SEL_A !== ea || BYPASS_SEL_B !== eb ||
                SEL_A2 !== ea || SEL_B2 !== eb || STALL_CNT !== 16'(mcnt) || CNT2 !== 2'(sat3(mcnt))) begin
                n_fail++;
                $display("FAIL random[%0d]: stall=%b/%b a=%0d b=%0d cnt=%0d cnt2=%0d required stall=%b a=%0d b=%0d cnt=%0d cnt2=%0d",
                         n, obs_stall, obs_stall2, BYPASS_SEL_A, BYPASS_SEL_B, STALL_CNT, CNT2,
                         es, ea, eb, mcnt, sat3(mcnt));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
